arb_req_queue: RTL and testbench

ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

---
 rtl/arb_pkg.sv | 19 +
 rtl/req_fifo.sv | 54 +++++
 rtl/arb_req_queue.sv | 89 ++++++++
 tb/tb_arb_req_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and client-index type for the request queue and arbiter.
// Holds default sizing and a multi-hot test helper.
package arb_pkg;

  localparam int N_DEF     = 4;
  localparam int DEPTH_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int IDW_DEF   = $clog2(N_DEF);

  typedef logic [IDW_DEF-1:0] cid_t;

  // True when two or more bits of v are set.
  function automatic logic multi_hot(
    input logic [31:0] v
  );
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Single in-order client queue; head is read combinationally.
// Ports: push/wdata in, pop in, rdata/empty/full/count out.
module req_fifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;

  // A pop frees the full slot in the same edge.
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/arb_req_queue.sv
// Per-client request queues feeding an external arbiter.
// Ports: push/push_data in, r out, g in, out_* / overflow / grant_err out.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int DW    = DW_DEF,
  localparam int IW    = $clog2(N),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    push,
  input  logic [N*DW-1:0] push_data,
  output logic [N-1:0]    r,
  input  logic [N-1:0]    g,
  output logic            out_valid,
  output logic [IW-1:0]   out_id,
  output logic [DW-1:0]   out_data,
  output logic [N-1:0]    overflow,
  output logic            grant_err
);

  logic [N-1:0]         empty;
  logic [N-1:0]         full;
  logic [N-1:0]         pop;
  logic [N-1:0]         sel;
  logic [N-1:0][CW-1:0] cnt;
  logic [DW-1:0]        head [N];
  logic [IW-1:0]        sel_id;
  logic [DW-1:0]        sel_data;

  for (genvar gi = 0; gi < N; gi++) begin : g_q
    req_fifo #(
      .DEPTH(DEPTH),
      .DW   (DW)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[gi]),
      .pop  (pop[gi]),
      .wdata(push_data[gi*DW +: DW]),
      .rdata(head[gi]),
      .empty(empty[gi]),
      .full (full[gi]),
      .count(cnt[gi])
    );
  end

  assign r = ~empty;

  // Multi-hot grants select nothing.
  assign sel = multi_hot(32'(g)) ? '0 : g;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++)
      pop[i] = sel[i] & (cnt[i] != '0);
  end

  always_comb begin
    sel_id = '0;
    for (int i = 0; i < N; i++)
      if (pop[i]) sel_id = IW'(i);
  end

  assign sel_data = head[sel_id];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      overflow  <= '0;
      grant_err <= 1'b0;
    end else begin
      out_valid <= |pop;
      if (|pop) begin
        out_id   <= sel_id;
        out_data <= sel_data;
      end
      overflow  <= push & full & ~pop;
      // Any grant that popped nothing is multi-hot or hit an empty queue.
      grant_err <= (|g) & ~(|pop);
    end
  end

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench with scoreboard queue of expected pops.
// Monitor compares each out_valid pulse against the queue head.
module tb_arb_req_queue;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  push;
  logic [31:0] push_data;
  logic [3:0]  r;
  logic [3:0]  g;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [7:0]  out_data;
  logic [3:0]  overflow;
  logic        grant_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  arb_req_queue dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .r        (r),
    .g        (g),
    .out_valid(out_valid),
    .out_id   (out_id),
    .out_data (out_data),
    .overflow (overflow),
    .grant_err(grant_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] p, input logic [31:0] d,
                      input logic [3:0] gg);
    push      = p;
    push_data = d;
    g         = gg;
    @(posedge clk);
    #1;
    push      = '0;
    push_data = '0;
    g         = '0;
  endtask

  task automatic expect_pop(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic grant(input logic [1:0] id, input logic [7:0] d);
    logic [3:0] gg;
    gg = 4'b0001 << id;
    expect_pop(id, d);
    step('0, '0, gg);
    chk("grant_no_err", 32'(grant_err), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pop_id", 32'(out_id), 32'(e.id));
        chk("pop_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst       = 1'b0;
    push      = '0;
    push_data = '0;
    g         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r", 32'(r), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_gerr", 32'(grant_err), 32'h0);
    rst = 1'b1;

    // single push/pop on client 2
    step(4'b0100, 32'h00A5_0000, '0);
    chk("t1_r", 32'(r), 32'h4);
    expect_pop(2'd2, 8'hA5);
    step('0, '0, 4'b0100);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_r_after", 32'(r), 32'h0);
    step('0, '0, '0);
    chk("t1_valid_pulse", 32'(out_valid), 32'h0);
    chk("t1_id_hold", 32'(out_id), 32'h2);
    chk("t1_data_hold", 32'(out_data), 32'hA5);

    // overflow on client 0
    for (int k = 1; k <= 4; k++) begin
      step(4'b0001, 32'(k), '0);
      chk("t2_no_ovf", 32'(overflow), 32'h0);
    end
    step(4'b0001, 32'h05, '0);
    chk("t2_ovf", 32'(overflow), 32'h1);
    step('0, '0, '0);
    chk("t2_ovf_pulse", 32'(overflow), 32'h0);
    for (int k = 1; k <= 4; k++) grant(2'd0, 8'(k));
    step('0, '0, '0);
    chk("t2_r_empty", 32'(r), 32'h0);

    // full client 1: push and pop together
    for (int k = 0; k < 4; k++) step(4'b0010, 32'(8'h11 + k) << 8, '0);
    expect_pop(2'd1, 8'h11);
    step(4'b0010, 32'h0000_1500, 4'b0010);
    chk("t3_no_ovf", 32'(overflow), 32'h0);
    chk("t3_valid", 32'(out_valid), 32'h1);
    step(4'b0010, 32'h0000_1600, '0);
    chk("t3_still_full", 32'(overflow), 32'h2);
    for (int k = 0; k < 4; k++) grant(2'd1, 8'(8'h12 + k));
    step('0, '0, '0);
    chk("t3_r_empty", 32'(r), 32'h0);

    // multi-hot grant
    step(4'b0011, 32'h0000_3121, '0);
    step('0, '0, 4'b0011);
    chk("t4_gerr", 32'(grant_err), 32'h1);
    chk("t4_valid", 32'(out_valid), 32'h0);
    chk("t4_r", 32'(r), 32'h3);
    grant(2'd0, 8'h21);
    grant(2'd1, 8'h31);

    // grant lag on emptied queue 3
    step(4'b1000, 32'h4400_0000, '0);
    expect_pop(2'd3, 8'h44);
    step('0, '0, 4'b1000);
    chk("t5_valid", 32'(out_valid), 32'h1);
    chk("t5_no_err", 32'(grant_err), 32'h0);
    step('0, '0, 4'b1000);
    chk("t5_gerr", 32'(grant_err), 32'h1);
    chk("t5_valid2", 32'(out_valid), 32'h0);
    step('0, '0, '0);
    chk("t5_gerr_pulse", 32'(grant_err), 32'h0);

    // push+grant on empty queue: no bypass
    step(4'b0100, 32'h0077_0000, 4'b0100);
    chk("t6_gerr", 32'(grant_err), 32'h1);
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_r", 32'(r), 32'h4);
    grant(2'd2, 8'h77);

    // reset mid-stream
    for (int k = 0; k < 3; k++) step(4'b0010, 32'(8'h51 + k) << 8, '0);
    chk("t7_r_pre", 32'(r), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_r_async", 32'(r), 32'h0);
    chk("t7_valid", 32'(out_valid), 32'h0);
    chk("t7_data", 32'(out_data), 32'h0);
    @(negedge clk);
    rst       = 1'b1;
    push      = 4'b0010;
    push_data = 32'h0000_9900;
    @(posedge clk);
    #1;
    push      = '0;
    push_data = '0;
    chk("t7_first_push", 32'(r), 32'h2);
    chk("t7_no_valid", 32'(out_valid), 32'h0);
    grant(2'd1, 8'h99);
    step('0, '0, '0);
    chk("t7_r_empty", 32'(r), 32'h0);

    repeat (2) step('0, '0, '0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
